serial_pattern_transmitter: RTL



---
 rtl/serial_pattern_pkg.sv | 20 ++
 rtl/serial_pattern_transmitter_tick_generator.sv | 26 ++
 rtl/serial_pattern_transmitter.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// Purpose: shared types and constants for the serial pattern transmitter and its helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 10;
  localparam int DEFAULT_TICK_LOG2 = 25;

  // Width needed to hold a bit index in 0..width-1, sized as $clog2(width+1).
  function automatic int index_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_transmitter_tick_generator.sv
// Purpose: free-running 2**TICK_LOG2 counter that emits a one-cycle tick when all ones.
// Latency: tick is decoded from the counter register, so it appears 2**TICK_LOG2-1 cycles after a clear.
// Backpressure: none; the counter never stalls, and only reset or clear restart it.
module tick_generator #(
  parameter int TICK_LOG2 = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [TICK_LOG2-1:0] count;

  // Counter wraps naturally; clear realigns the bit period to a word start.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count + TICK_LOG2'(1);
    end
  end

  assign tick = &count;

endmodule

// File: rtl/serial_pattern_transmitter.sv
// Purpose: latches a WIDTH-bit word on start and shifts it out LSB-first, one bit per tick.
// Latency: first bit on serial_out the cycle after accept; done pulses WIDTH*2**TICK_LOG2+1 cycles after accept.
// Backpressure: ready is low while sending and in the done cycle; start is ignored then.
module serial_pattern_transmitter
  import serial_pattern_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter int   TICK_LOG2  = DEFAULT_TICK_LOG2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [WIDTH-1:0]                data_in,
  output logic                            ready,
  output logic                            busy,
  output logic                            serial_out,
  output logic                            bit_strobe,
  output logic [index_width(WIDTH)-1:0]   bit_index,
  output logic                            done
);

  localparam int               IDX_W    = index_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             tick;
  logic             load;
  logic             advance;

  // The tick counter restarts on every accepted word so bit periods line up with the accept cycle.
  tick_generator #(
    .TICK_LOG2 (TICK_LOG2)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (load),
    .tick  (tick)
  );

  // State register plus shift register and index; reset overrides any start in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_index <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg     <= data_in;
        bit_index <= '0;
      end else if (advance) begin
        shreg     <= shreg >> 1;
        bit_index <= bit_index + IDX_W'(1);
      end
    end
  end

  // Next-state and output decode; outputs depend only on registered state, shreg and the tick.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    serial_out = IDLE_LEVEL;
    bit_strobe = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        busy       = 1'b1;
        serial_out = shreg[0];
        if (tick) begin
          bit_strobe = 1'b1;
          if (bit_index == LAST_IDX) begin
            state_next = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
